pc_gen_unit: RTL and testbench

Program-counter generation stage of the RV32I core. Consumes `branch_taken` from the branch unit, plus target operands from execute, trap/return requests from the CSR unit and stall from the memory interface. Holds the architectural fetch PC and drives the instruction-memory address. Emits a one-cycle flush pulse that kills the instruction fetched down the wrong path, and flags misaligned jump/branch targets.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/pc_target_calc.sv | 24 ++
 rtl/pc_gen_unit.sv | 103 ++++++++++
 tb/tb_pc_gen_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode[6:2] constants, PC-generator FSM encoding
// and the default boot address.
package riscv_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCG_BOOT  = 2'd0,
        PCG_RUN   = 2'd1,
        PCG_FLUSH = 2'd2
    } pcg_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational jump/branch target calculation, redirect request decode and
// misaligned-target detection for the instruction currently in execute.
module pc_target_calc
    import riscv_pkg::*;
(
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    output logic [31:0] target_out,
    output logic        redirect_out,
    output logic        misaligned_out
);

    logic is_jalr;

    // The branch unit never flags JALR, so it is decoded here.
    assign is_jalr        = (opcode_6_to_2_in == OP_JALR);
    assign target_out     = is_jalr ? ((rs1_in + imm_in) & ~32'h1) : (ex_pc_in + imm_in);
    assign redirect_out   = branch_taken_in | is_jalr;
    assign misaligned_out = redirect_out & (target_out[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: holds the architectural fetch PC, applies trap/MRET/
// branch/JALR redirects by priority and pulses flush after every redirect.
module pc_gen_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] i_addr_out,
    output logic        flush_out,
    output logic        misaligned_out,
    output logic [31:0] misaligned_addr_out,
    output logic [1:0]  state_out
);

    pcg_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;
    logic [31:0] maddr_q, maddr_d;

    logic [31:0] target;
    logic        redirect;
    logic        target_misaligned;

    pc_target_calc u_target (
        .branch_taken_in  (branch_taken_in),
        .opcode_6_to_2_in (opcode_6_to_2_in),
        .ex_pc_in         (ex_pc_in),
        .imm_in           (imm_in),
        .rs1_in           (rs1_in),
        .target_out       (target),
        .redirect_out     (redirect),
        .misaligned_out   (target_misaligned)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= PCG_BOOT;
            pc_q    <= BOOT_ADDR;
            mis_q   <= 1'b0;
            maddr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
        end
    end

    // Trap and MRET override a stall; BOOT refetches BOOT_ADDR because the
    // fetch issued during reset is killed by the BOOT flush.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        maddr_d = maddr_q;
        if (trap_taken_in) begin
            pc_d    = trap_vector_in;
            state_d = PCG_FLUSH;
        end else if (mret_in) begin
            pc_d    = epc_in;
            state_d = PCG_FLUSH;
        end else if (stall_in) begin
            state_d = state_q;
        end else if (state_q == PCG_BOOT) begin
            pc_d    = BOOT_ADDR;
            state_d = PCG_RUN;
        end else if (redirect && target_misaligned) begin
            pc_d    = pc_q + 32'd4;
            mis_d   = 1'b1;
            maddr_d = target;
            state_d = PCG_RUN;
        end else if (redirect) begin
            pc_d    = target;
            state_d = PCG_FLUSH;
        end else begin
            pc_d    = pc_q + 32'd4;
            state_d = PCG_RUN;
        end
    end

    assign pc_out              = pc_q;
    assign i_addr_out          = pc_q;
    assign pc_plus_4_out       = pc_q + 32'd4;
    assign flush_out           = (state_q != PCG_RUN);
    assign misaligned_out      = mis_q;
    assign misaligned_addr_out = maddr_q;
    assign state_out           = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed walk through boot, redirects, stall, trap,
// MRET, wrap-around and async reset, then randomized traffic against a model.
module tb_pc_gen_unit;
    import riscv_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_1000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        branch_taken_in;
    logic [4:0]  opcode_6_to_2_in;
    logic [31:0] ex_pc_in;
    logic [31:0] imm_in;
    logic [31:0] rs1_in;
    logic        trap_taken_in;
    logic [31:0] trap_vector_in;
    logic        mret_in;
    logic [31:0] epc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] i_addr_out;
    logic        flush_out;
    logic        misaligned_out;
    logic [31:0] misaligned_addr_out;
    logic [1:0]  state_out;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    pc_gen_unit #(.BOOT_ADDR(BOOT)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .stall_in            (stall_in),
        .branch_taken_in     (branch_taken_in),
        .opcode_6_to_2_in    (opcode_6_to_2_in),
        .ex_pc_in            (ex_pc_in),
        .imm_in              (imm_in),
        .rs1_in              (rs1_in),
        .trap_taken_in       (trap_taken_in),
        .trap_vector_in      (trap_vector_in),
        .mret_in             (mret_in),
        .epc_in              (epc_in),
        .pc_out              (pc_out),
        .pc_plus_4_out       (pc_plus_4_out),
        .i_addr_out          (i_addr_out),
        .flush_out           (flush_out),
        .misaligned_out      (misaligned_out),
        .misaligned_addr_out (misaligned_addr_out),
        .state_out           (state_out)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    // m_boot: still waiting for the post-reset refetch; m_flush: flush expected.
    logic [31:0] m_pc, m_maddr;
    logic        m_flush, m_boot, m_mis;
    logic [31:0] m_tgt;
    logic        m_redir, m_bad;

    assign m_tgt   = (opcode_6_to_2_in == OP_JALR) ? ((rs1_in + imm_in) & 32'hFFFF_FFFE)
                                                   : (ex_pc_in + imm_in);
    assign m_redir = branch_taken_in || (opcode_6_to_2_in == OP_JALR);
    assign m_bad   = m_redir && ((m_tgt % 4) != 0);

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_pc <= BOOT; m_flush <= 1'b1; m_boot <= 1'b1; m_mis <= 1'b0; m_maddr <= 32'h0;
        end else begin
            m_mis <= 1'b0;
            if (trap_taken_in) begin
                m_pc <= trap_vector_in; m_flush <= 1'b1; m_boot <= 1'b0;
            end else if (mret_in) begin
                m_pc <= epc_in; m_flush <= 1'b1; m_boot <= 1'b0;
            end else if (stall_in) begin
                m_pc <= m_pc;
            end else if (m_boot) begin
                m_pc <= BOOT; m_flush <= 1'b0; m_boot <= 1'b0;
            end else if (m_bad) begin
                m_pc <= m_pc + 32'd4; m_flush <= 1'b0; m_mis <= 1'b1; m_maddr <= m_tgt;
            end else if (m_redir) begin
                m_pc <= m_tgt; m_flush <= 1'b1;
            end else begin
                m_pc <= m_pc + 32'd4; m_flush <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (check_en) begin
            logic [1:0] exp_state;
            exp_state = m_boot ? 2'(PCG_BOOT) : (m_flush ? 2'(PCG_FLUSH) : 2'(PCG_RUN));
            chk("model_pc",      pc_out,              m_pc);
            chk("model_pc4",     pc_plus_4_out,       m_pc + 32'd4);
            chk("model_iaddr",   i_addr_out,          m_pc);
            chk("model_flush",   32'(flush_out),      32'(m_flush));
            chk("model_mis",     32'(misaligned_out), 32'(m_mis));
            chk("model_maddr",   misaligned_addr_out, m_maddr);
            chk("model_state",   32'(state_out),      32'(exp_state));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        stall_in = 0; branch_taken_in = 0; opcode_6_to_2_in = 5'b01100;
        ex_pc_in = 0; imm_in = 0; rs1_in = 0;
        trap_taken_in = 0; trap_vector_in = 0; mret_in = 0; epc_in = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input logic fl);
        chk({name, "_pc"}, pc_out, pc);
        chk({name, "_flush"}, 32'(flush_out), 32'(fl));
    endtask

    task automatic rand_inputs();
        int r;
        idle();
        stall_in        = ($urandom_range(0, 3) == 0);
        branch_taken_in = ($urandom_range(0, 9) < 3);
        r = $urandom_range(0, 3);
        opcode_6_to_2_in = (r == 0) ? OP_BRANCH : (r == 1) ? OP_JAL :
                           (r == 2) ? OP_JALR : 5'b00100;
        ex_pc_in = $urandom() & 32'hFFFF_FFFC;
        imm_in   = 32'($signed($urandom_range(0, 2047)) - 1024);
        if ($urandom_range(0, 4) != 0) imm_in = imm_in & 32'hFFFF_FFFC;
        rs1_in   = $urandom();
        trap_taken_in  = ($urandom_range(0, 19) == 0);
        trap_vector_in = $urandom() & 32'hFFFF_FFFC;
        mret_in        = ($urandom_range(0, 19) == 0);
        epc_in         = $urandom() & 32'hFFFF_FFFC;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst_in = 1'b0;
        step(2);
        lit("reset", BOOT, 1'b1);
        chk("reset_mis", 32'(misaligned_out), 32'h0);
        chk("reset_maddr", misaligned_addr_out, 32'h0);
        chk("reset_state", 32'(state_out), 32'(PCG_BOOT));
        rst_in = 1'b1;
        check_en = 1'b1;
        step(1); lit("boot0", 32'h1000, 1'b0);
        step(1); lit("boot1", 32'h1004, 1'b0);
        step(1); lit("boot2", 32'h1008, 1'b0);

        branch_taken_in = 1; opcode_6_to_2_in = OP_BRANCH; ex_pc_in = 32'h1008; imm_in = -32'sd8;
        step(1); lit("br", 32'h1000, 1'b1);
        idle();
        step(1); lit("br_after", 32'h1004, 1'b0);

        opcode_6_to_2_in = OP_JALR; rs1_in = 32'h2003; imm_in = 0;
        step(1); lit("jalr_mis", 32'h1008, 1'b0);
        chk("jalr_mis_flag", 32'(misaligned_out), 32'h1);
        chk("jalr_mis_addr", misaligned_addr_out, 32'h2002);
        idle();
        step(1); chk("jalr_mis_clear", 32'(misaligned_out), 32'h0);
        lit("jalr_mis_seq", 32'h100C, 1'b0);

        opcode_6_to_2_in = OP_JALR; rs1_in = 32'h2001; imm_in = 0;
        step(1); lit("jalr_ok", 32'h2000, 1'b1);
        idle();
        step(1); lit("jalr_ok_seq", 32'h2004, 1'b0);

        stall_in = 1; branch_taken_in = 1; opcode_6_to_2_in = OP_BRANCH;
        ex_pc_in = 32'h3000; imm_in = 32'h100;
        step(3); lit("stall3", 32'h2004, 1'b0);
        trap_taken_in = 1; trap_vector_in = 32'h80;
        step(1); lit("trap_stall", 32'h80, 1'b1);
        trap_taken_in = 0;
        step(1); lit("flush_hold", 32'h80, 1'b1);
        idle();
        step(1); lit("after_trap", 32'h84, 1'b0);

        trap_taken_in = 1; trap_vector_in = 32'h200;
        branch_taken_in = 1; opcode_6_to_2_in = OP_BRANCH; ex_pc_in = 32'h3000; imm_in = 4;
        step(1); lit("trap_wins", 32'h200, 1'b1);
        idle(); mret_in = 1; epc_in = 32'h1010;
        step(1); lit("mret", 32'h1010, 1'b1);
        idle();

        trap_taken_in = 1; trap_vector_in = 32'hFFFF_FFFC;
        step(1); chk("wrap_pc4", pc_plus_4_out, 32'h0);
        idle();
        step(1); lit("wrap", 32'h0, 1'b0);
        chk("wrap_mis", 32'(misaligned_out), 32'h0);

        branch_taken_in = 1; opcode_6_to_2_in = OP_JAL; ex_pc_in = 32'h40; imm_in = 0;
        step(1); lit("pre_rst", 32'h40, 1'b1);
        idle();
        #2 rst_in = 1'b0;
        #1;
        lit("async_rst", BOOT, 1'b1);
        chk("async_rst_maddr", misaligned_addr_out, 32'h0);
        chk("async_rst_state", 32'(state_out), 32'(PCG_BOOT));
        @(negedge clk_in); #1 rst_in = 1'b1;

        for (int i = 0; i < 600; i++) begin
            step(1);
            rand_inputs();
        end
        idle();
        step(2);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
